// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, mid-bit sampling, parity/framing checks, break hold-off.
// valid strobes one cycle after the final stop sample; no backpressure, so the consumer must take every word.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW   = $clog2(DATA_BITS);
  localparam int HALF = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic          ODD      = (PARITY == 1);
  localparam logic          HAS_PAR  = (PARITY != 0);
  localparam logic          ONE_STOP = (STOP_BITS == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 rx_m;
  logic                 rx_s;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic                 stop_bad;
  logic                 par_bad;
  logic [DATA_BITS-1:0] shift;

  logic tick;
  logic half_tick;
  logic last_stop;
  logic stop_bad_now;

  assign tick         = (cnt == CNT_LAST);
  assign half_tick    = (cnt == CNT_HALF);
  assign last_stop    = ONE_STOP | stop_idx;
  assign stop_bad_now = stop_bad | ~rx_s;
  assign busy         = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!rx_s) state_nxt = S_START;
      end
      S_START: begin
        // A start bit that has gone high again by mid-bit is a glitch.
        if (half_tick) state_nxt = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (tick && (bit_idx == BIT_LAST)) state_nxt = HAS_PAR ? S_PAR : S_STOP;
      end
      S_PAR: begin
        if (tick) state_nxt = S_STOP;
      end
      S_STOP: begin
        if (tick && last_stop) state_nxt = stop_bad_now ? S_BREAK : S_IDLE;
      end
      S_BREAK: begin
        // Wait for the line to release so a held-low line cannot re-trigger a start.
        if (rx_s) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      cnt        <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      stop_bad   <= 1'b0;
      par_bad    <= 1'b0;
      shift      <= '0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_m  <= rx;
      rx_s  <= rx_m;
      valid <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt      <= '0;
          bit_idx  <= '0;
          stop_idx <= 1'b0;
          stop_bad <= 1'b0;
          par_bad  <= 1'b0;
        end
        S_START: begin
          cnt <= half_tick ? '0 : cnt + 1'b1;
        end
        S_DATA: begin
          cnt <= tick ? '0 : cnt + 1'b1;
          if (tick) begin
            // Shifting in at the MSB leaves the first (LSB) bit at position 0 after the last shift.
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
          end
        end
        S_PAR: begin
          cnt <= tick ? '0 : cnt + 1'b1;
          if (tick) par_bad <= rx_s ^ (^shift) ^ ODD;
        end
        S_STOP: begin
          cnt <= tick ? '0 : cnt + 1'b1;
          if (tick) begin
            stop_idx <= 1'b1;
            stop_bad <= stop_bad_now;
            if (last_stop) begin
              data       <= shift;
              valid      <= 1'b1;
              parity_err <= par_bad;
              frame_err  <= stop_bad_now;
            end
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three instances cover 8N1, 8E1 and 7O2 framing at 16 clocks per bit.
module tb_uart_rx_param;

  logic clk = 1'b0;
  logic reset;
  logic rx_a, rx_b, rx_c;

  logic [7:0] data_a, data_b;
  logic [6:0] data_c;
  logic valid_a, valid_b, valid_c;
  logic perr_a, perr_b, perr_c;
  logic ferr_a, ferr_b, ferr_c;
  logic busy_a, busy_b, busy_c;

  int checks = 0;
  int failures = 0;
  logic busy_all;

  // Each delivered word is logged as {parity_err, frame_err, 9-bit data}.
  logic [10:0] q_a[$];
  logic [10:0] q_b[$];
  logic [10:0] q_c[$];

  always #5 clk = ~clk;

  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .reset(reset), .rx(rx_a), .data(data_a), .valid(valid_a),
    .parity_err(perr_a), .frame_err(ferr_a), .busy(busy_a));

  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
    .clk(clk), .reset(reset), .rx(rx_b), .data(data_b), .valid(valid_b),
    .parity_err(perr_b), .frame_err(ferr_b), .busy(busy_b));

  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_c (
    .clk(clk), .reset(reset), .rx(rx_c), .data(data_c), .valid(valid_c),
    .parity_err(perr_c), .frame_err(ferr_c), .busy(busy_c));

  always @(negedge clk) begin
    if (valid_a) q_a.push_back({perr_a, ferr_a, 1'b0, data_a});
    if (valid_b) q_b.push_back({perr_b, ferr_b, 1'b0, data_b});
    if (valid_c) q_c.push_back({perr_c, ferr_c, 2'b00, data_c});
  end

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int w, input logic v);
    case (w)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  function automatic logic get_busy(input int w);
    case (w)
      0: return busy_a;
      1: return busy_b;
      default: return busy_c;
    endcase
  endfunction

  // Drives n bits LSB first, 16 clocks each; busy_all records busy at mid-bit of all interior bits.
  task automatic drive_frame(input int w, input logic [15:0] bits, input int n);
    busy_all = 1'b1;
    for (int i = 0; i < n; i++) begin
      set_rx(w, bits[i]);
      idle(8);
      if (i > 0 && i < n - 1) busy_all = busy_all & get_busy(w);
      idle(8);
    end
  endtask

  task automatic test_reset;
    logic [15:0] dummy;
    dummy = '0;
    reset = 1'b1;
    rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    idle(3);
    checks++; if (data_a !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data_a); end
    checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_a); end
    checks++; if ({perr_a, ferr_a} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {perr_a, ferr_a}); end
    checks++; if ({busy_a, busy_b, busy_c} !== 3'b000) begin failures++; $display("FAIL reset_busy got=%b exp=000", {busy_a, busy_b, busy_c}); end
    reset = 1'b0;
    idle(4 + int'(dummy[0]));
  endtask

  task automatic test_back_to_back;
    int n0;
    logic b1, b2;
    n0 = q_a.size();
    drive_frame(0, {6'h3F, 1'b1, 8'hA5, 1'b0}, 10);
    b1 = busy_all;
    drive_frame(0, {6'h3F, 1'b1, 8'h3C, 1'b0}, 10);
    b2 = busy_all;
    idle(10);
    checks++; if (q_a.size() !== n0 + 2) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", q_a.size(), n0 + 2); end
    checks++; if (q_a[n0] !== 11'h0A5) begin failures++; $display("FAIL b2b_first got=%h exp=0a5", q_a[n0]); end
    checks++; if (q_a[n0+1] !== 11'h03C) begin failures++; $display("FAIL b2b_second got=%h exp=03c", q_a[n0+1]); end
    checks++; if ({b1, b2} !== 2'b11) begin failures++; $display("FAIL b2b_busy got=%b exp=11", {b1, b2}); end
  endtask

  task automatic test_parity;
    int n0;
    n0 = q_b.size();
    drive_frame(1, {5'h1F, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
    drive_frame(1, {5'h1F, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    idle(10);
    checks++; if (q_b.size() !== n0 + 2) begin failures++; $display("FAIL par_count got=%0d exp=%0d", q_b.size(), n0 + 2); end
    checks++; if (q_b[n0] !== 11'h007) begin failures++; $display("FAIL par_good got=%h exp=007", q_b[n0]); end
    checks++; if (q_b[n0+1] !== 11'h407) begin failures++; $display("FAIL par_bad got=%h exp=407", q_b[n0+1]); end
  endtask

  task automatic test_glitch;
    int n0;
    n0 = q_a.size();
    rx_a = 1'b0;
    idle(5);
    rx_a = 1'b1;
    idle(30);
    checks++; if (q_a.size() !== n0) begin failures++; $display("FAIL glitch_novalid got=%0d exp=%0d", q_a.size(), n0); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL glitch_busy got=%b exp=0", busy_a); end
    checks++; if (data_a !== 8'h3C) begin failures++; $display("FAIL glitch_hold got=%h exp=3c", data_a); end
    drive_frame(0, {6'h3F, 1'b1, 8'h55, 1'b0}, 10);
    idle(10);
    checks++; if (q_a.size() !== n0 + 1) begin failures++; $display("FAIL glitch_next_count got=%0d exp=%0d", q_a.size(), n0 + 1); end
    checks++; if (q_a[n0] !== 11'h055) begin failures++; $display("FAIL glitch_next got=%h exp=055", q_a[n0]); end
  endtask

  task automatic test_break;
    int n0;
    n0 = q_a.size();
    drive_frame(0, {6'h00, 1'b0, 8'h81, 1'b0}, 10);
    idle(40);
    checks++; if (q_a.size() !== n0 + 1) begin failures++; $display("FAIL brk_count got=%0d exp=%0d", q_a.size(), n0 + 1); end
    checks++; if (q_a[n0] !== 11'h281) begin failures++; $display("FAIL brk_word got=%h exp=281", q_a[n0]); end
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL brk_busy_low got=%b exp=1", busy_a); end
    rx_a = 1'b1;
    idle(20);
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL brk_release got=%b exp=0", busy_a); end
    drive_frame(0, {6'h3F, 1'b1, 8'h42, 1'b0}, 10);
    idle(10);
    checks++; if (q_a.size() !== n0 + 2) begin failures++; $display("FAIL brk_next_count got=%0d exp=%0d", q_a.size(), n0 + 2); end
    checks++; if (q_a[n0+1] !== 11'h042) begin failures++; $display("FAIL brk_next got=%h exp=042", q_a[n0+1]); end
  endtask

  task automatic test_7o2;
    int n0;
    n0 = q_c.size();
    drive_frame(2, {5'h1F, 1'b1, 1'b1, 1'b1, 7'h5A, 1'b0}, 11);
    idle(10);
    checks++; if (q_c.size() !== n0 + 1) begin failures++; $display("FAIL o2_count got=%0d exp=%0d", q_c.size(), n0 + 1); end
    checks++; if (q_c[n0] !== 11'h05A) begin failures++; $display("FAIL o2_good got=%h exp=05a", q_c[n0]); end
    drive_frame(2, {5'h1F, 1'b0, 1'b1, 1'b1, 7'h5A, 1'b0}, 11);
    rx_c = 1'b1;
    idle(20);
    checks++; if (q_c.size() !== n0 + 2) begin failures++; $display("FAIL o2_count2 got=%0d exp=%0d", q_c.size(), n0 + 2); end
    checks++; if (q_c[n0+1] !== 11'h25A) begin failures++; $display("FAIL o2_stop2 got=%h exp=25a", q_c[n0+1]); end
    checks++; if (busy_c !== 1'b0) begin failures++; $display("FAIL o2_busy got=%b exp=0", busy_c); end
  endtask

  task automatic test_reset_midframe;
    int n0;
    logic [15:0] bits;
    n0 = q_a.size();
    bits = {6'h3F, 1'b1, 8'hF8, 1'b0};
    for (int i = 0; i < 4; i++) begin
      rx_a = bits[i];
      idle(16);
    end
    rx_a = bits[4];
    idle(8);
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL mid_busy_before got=%b exp=1", busy_a); end
    reset = 1'b1;
    idle(1);
    checks++; if ({data_a, valid_a, busy_a, perr_a, ferr_a} !== 12'h000) begin
      failures++; $display("FAIL mid_reset got=%h exp=000", {data_a, valid_a, busy_a, perr_a, ferr_a});
    end
    reset = 1'b0;
    idle(7 + 16 * 5 + 20);
    checks++; if (q_a.size() !== n0) begin failures++; $display("FAIL mid_novalid got=%0d exp=%0d", q_a.size(), n0); end
    drive_frame(0, {6'h3F, 1'b1, 8'hF0, 1'b0}, 10);
    idle(10);
    checks++; if (q_a.size() !== n0 + 1) begin failures++; $display("FAIL mid_next_count got=%0d exp=%0d", q_a.size(), n0 + 1); end
    checks++; if (q_a[n0] !== 11'h0F0) begin failures++; $display("FAIL mid_next got=%h exp=0f0", q_a[n0]); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_parity();
    test_glitch();
    test_break();
    test_7o2();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
